distortion_sched: RTL and testbench
===================================

DISTORTION_SCHED -- requirements
Module: distortion_sched

Interface
Parameters:
REQ-001 SHALL provide parameter DIN_WIDTH, default 32, sample width in bits (signed two's complement).
REQ-002 SHALL provide parameter WAIT_TIMEOUT, default 16, maximum cycles spent in WAIT before aborting (range 1..255).

Ports:
REQ-003 SHALL provide clk  in  1  single clock; every register updates on its rising edge.
REQ-004 SHALL provide rst  in  1  synchronous, active-high reset.
REQ-005 SHALL provide s0_tdata/s0_tvalid/s0_tready  in/in/out  DIN_WIDTH/1/1  channel-0 input stream (left).
REQ-006 SHALL provide s1_tdata/s1_tvalid/s1_tready  in/in/out  DIN_WIDTH/1/1  channel-1 input stream (right).
REQ-007 SHALL provide core_din/core_din_tvalid/core_din_tready  out/out/in  DIN_WIDTH/1/1  request path to the shared distortion core.
REQ-008 SHALL provide core_dout/core_dout_tvalid/core_dout_tready  in/in/out  DIN_WIDTH/1/1  response path from the shared core.
REQ-009 SHALL provide m0_tdata/m0_tvalid/m0_tready  out/out/in  DIN_WIDTH/1/1  channel-0 output stream.
REQ-010 SHALL provide m1_tdata/m1_tvalid/m1_tready  out/out/in  DIN_WIDTH/1/1  channel-1 output stream.
REQ-011 SHALL provide err_timeout  out  1  sticky flag, set when a core transaction times out.

Function
REQ-012 SHALL time-share one distortion core between two channels using a four-state FSM: IDLE, ISSUE, WAIT, DELIVER.
REQ-013 IDLE: if exactly one sN_tvalid is high, SHALL grant that channel; if both are high, SHALL grant the channel not served last (round-robin pointer).
REQ-014 On grant, SHALL assert the granted sN_tready combinationally for that cycle only, capture tdata and channel tag, move to ISSUE, and update the round-robin pointer.
REQ-015 SHALL hold s0_tready and s1_tready low in every state except IDLE, and never assert both in the same cycle.
REQ-016 ISSUE: SHALL drive core_din from the captured sample with core_din_tvalid high until core_din_tready is high, then move to WAIT.
REQ-017 SHALL drive core_dout_tready high in IDLE and WAIT and low in ISSUE and DELIVER; responses arriving in IDLE are discarded (stale-flush).
REQ-018 WAIT: on core_dout_tvalid, SHALL capture core_dout and move to DELIVER; a 8-bit counter SHALL count WAIT cycles.
REQ-019 If the WAIT count reaches WAIT_TIMEOUT without core_dout_tvalid, SHALL load 0 as the result, set err_timeout, and move to DELIVER.
REQ-020 DELIVER: SHALL assert mN_tvalid only for the tagged channel, with mN_tdata = the captured result, held stable until mN_tready, then return to IDLE.
REQ-021 A stalled output channel SHALL block the scheduler (no new grant) until its mN_tready.
REQ-022 With core latency 1 and all readies high, SHALL sustain one sample per 4 cycles: accept T, issue T+1, capture T+2, deliver T+3.
REQ-023 SHALL pass data unmodified in width and sign; no arithmetic on samples except the timeout zero.
REQ-024 Inactive mN_tdata SHALL hold its last value; m0_tvalid and m1_tvalid are never high together.

Reset
REQ-025 When rst is high at a clock edge, SHALL enter IDLE, clear all tvalid outputs, zero the captured data and result registers and the WAIT counter, clear err_timeout, and set the round-robin pointer so channel 0 wins the first tie.
REQ-026 Reset in any state SHALL discard the in-flight sample with no output produced; err_timeout is cleared only by reset.

Configuration
REQ-027 Macro DISTORTION_SCHED_BYPASS_EN, when defined, SHALL add input bypass [1:0]; a grant to a channel whose bit is high SHALL go from IDLE directly to DELIVER with the raw sample, never touching the core.
REQ-028 Without DISTORTION_SCHED_BYPASS_EN, the bypass port SHALL not exist and every sample SHALL route through the core.

Verification
REQ-029 Single sample: s0 = 0x00000100, model core (1-cycle, 2x gain) -> m0_tdata = 0x00000200 exactly 3 cycles after acceptance; m1_tvalid stays low.
REQ-030 Tie: s0 and s1 both valid continuously after reset -> grants alternate 0,1,0,1 over 8 samples; per-channel order preserved.
REQ-031 Timeout: WAIT_TIMEOUT = 4, core never responds -> m-side result 0 after 4 WAIT cycles, err_timeout = 1 until rst.
REQ-032 Backpressure: m1_tready low for 10 cycles -> m1_tdata stable, s0_tready stays low throughout, delivery on the first ready cycle.
REQ-033 Reset during WAIT -> next cycle IDLE, no mN_tvalid; the late core response is flushed and a new sample is processed correctly.
REQ-034 With DISTORTION_SCHED_BYPASS_EN, bypass = 2'b10, s1 = 0x7FFFFFFF -> m1_tdata = 0x7FFFFFFF and core_din_tvalid never asserted.

Source files
------------

// File: rtl/distortion_sched.sv
// Round-robin scheduler sharing one distortion core between two sample streams.
// Optional macro DISTORTION_SCHED_BYPASS_EN adds a per-channel core bypass input.
module distortion_sched #(
    parameter int DIN_WIDTH    = 32,
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef DISTORTION_SCHED_BYPASS_EN
    input  logic [1:0]           bypass,
`endif
    input  logic [DIN_WIDTH-1:0] s0_tdata,
    input  logic                 s0_tvalid,
    output logic                 s0_tready,
    input  logic [DIN_WIDTH-1:0] s1_tdata,
    input  logic                 s1_tvalid,
    output logic                 s1_tready,
    output logic [DIN_WIDTH-1:0] core_din,
    output logic                 core_din_tvalid,
    input  logic                 core_din_tready,
    input  logic [DIN_WIDTH-1:0] core_dout,
    input  logic                 core_dout_tvalid,
    output logic                 core_dout_tready,
    output logic [DIN_WIDTH-1:0] m0_tdata,
    output logic                 m0_tvalid,
    input  logic                 m0_tready,
    output logic [DIN_WIDTH-1:0] m1_tdata,
    output logic                 m1_tvalid,
    input  logic                 m1_tready,
    output logic                 err_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

    state_t                 state_r, state_nxt_s;
    logic [DIN_WIDTH-1:0]   data_r, m0_data_r, m1_data_r;
    logic [DIN_WIDTH-1:0]   res_val_s;
    logic [7:0]             wait_cnt_r;
    logic                   tag_r, rr_last_r, err_timeout_r;
    logic                   grant_s, grant_ch_s, bypass_s, timeout_s;
    logic                   res_load_s, res_ch_s, m_ready_s;

`ifdef DISTORTION_SCHED_BYPASS_EN
    assign bypass_s = grant_ch_s ? bypass[1] : bypass[0];
`else
    assign bypass_s = 1'b0;
`endif

    assign timeout_s = (state_r == ST_WAIT) && !core_dout_tvalid && (wait_cnt_r == WAIT_LAST);
    assign m_ready_s = tag_r ? m1_tready : m0_tready;

    // Arbitration: on a tie the channel not served last wins
    always_comb begin
        grant_s    = 1'b0;
        grant_ch_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (s0_tvalid && s1_tvalid) begin
                grant_s    = 1'b1;
                grant_ch_s = ~rr_last_r;
            end else if (s0_tvalid || s1_tvalid) begin
                grant_s    = 1'b1;
                grant_ch_s = s1_tvalid;
            end else begin
                grant_s    = 1'b0;
            end
        end else begin
            grant_s = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:    if (grant_s) state_nxt_s = bypass_s ? ST_DELIVER : ST_ISSUE;
                        else         state_nxt_s = ST_IDLE;
            ST_ISSUE:   if (core_din_tready) state_nxt_s = ST_WAIT;
                        else                 state_nxt_s = ST_ISSUE;
            ST_WAIT:    if (core_dout_tvalid || timeout_s) state_nxt_s = ST_DELIVER;
                        else                               state_nxt_s = ST_WAIT;
            ST_DELIVER: if (m_ready_s) state_nxt_s = ST_IDLE;
                        else           state_nxt_s = ST_DELIVER;
            default:    state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode; core responses are accepted (and dropped) while idle
    always_comb begin
        s0_tready        = grant_s && !grant_ch_s;
        s1_tready        = grant_s && grant_ch_s;
        core_din_tvalid  = (state_r == ST_ISSUE);
        core_dout_tready = (state_r == ST_IDLE) || (state_r == ST_WAIT);
        m0_tvalid        = (state_r == ST_DELIVER) && !tag_r;
        m1_tvalid        = (state_r == ST_DELIVER) && tag_r;
    end

    // Result selection: raw sample on bypass, core reply, or zero on timeout
    always_comb begin
        res_load_s = 1'b0;
        res_ch_s   = tag_r;
        res_val_s  = {DIN_WIDTH{1'b0}};
        if (grant_s && bypass_s) begin
            res_load_s = 1'b1;
            res_ch_s   = grant_ch_s;
            res_val_s  = grant_ch_s ? s1_tdata : s0_tdata;
        end else if (state_r == ST_WAIT && core_dout_tvalid) begin
            res_load_s = 1'b1;
            res_val_s  = core_dout;
        end else if (timeout_s) begin
            res_load_s = 1'b1;
            res_val_s  = {DIN_WIDTH{1'b0}};
        end else begin
            res_load_s = 1'b0;
        end
    end

    // Datapath registers, round-robin pointer, wait counter and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r        <= {DIN_WIDTH{1'b0}};
            m0_data_r     <= {DIN_WIDTH{1'b0}};
            m1_data_r     <= {DIN_WIDTH{1'b0}};
            tag_r         <= 1'b0;
            rr_last_r     <= 1'b1;
            wait_cnt_r    <= 8'd0;
            err_timeout_r <= 1'b0;
        end else begin
            if (grant_s) begin
                data_r    <= grant_ch_s ? s1_tdata : s0_tdata;
                tag_r     <= grant_ch_s;
                rr_last_r <= grant_ch_s;
            end
            if (res_load_s && res_ch_s) begin
                m1_data_r <= res_val_s;
            end else if (res_load_s) begin
                m0_data_r <= res_val_s;
            end
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end else begin
                wait_cnt_r <= 8'd0;
            end
            if (timeout_s) begin
                err_timeout_r <= 1'b1;
            end
        end
    end

    assign core_din    = data_r;
    assign m0_tdata    = m0_data_r;
    assign m1_tdata    = m1_data_r;
    assign err_timeout = err_timeout_r;

endmodule

// File: tb/tb_distortion_sched.sv
// Directed bench for distortion_sched with a behavioural 2x-gain core of programmable latency.
module tb_distortion_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s0_tdata = 32'd0, s1_tdata = 32'd0;
    logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic        s0_tready, s1_tready;
    logic [31:0] core_din, core_dout;
    logic        core_din_tvalid, core_dout_tready, core_dout_tvalid;
    logic        core_din_tready = 1'b1;
    logic [31:0] m0_tdata, m1_tdata;
    logic        m0_tvalid, m1_tvalid;
    logic        m0_tready = 1'b1, m1_tready = 1'b1;
    logic        err_timeout;
    logic [1:0]  bypass = 2'b00;

    int vectors = 0;
    int miscompares = 0;

    // Core model: latency 0 means it never answers
    int          core_lat = 1;
    logic        core_pend = 1'b0;
    logic [31:0] core_q = 32'd0;
    int          core_cnt = 0;

    always #5 clk = ~clk;

    distortion_sched #(.DIN_WIDTH(32), .WAIT_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
`ifdef DISTORTION_SCHED_BYPASS_EN
        .bypass(bypass),
`endif
        .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .core_din(core_din), .core_din_tvalid(core_din_tvalid), .core_din_tready(core_din_tready),
        .core_dout(core_dout), .core_dout_tvalid(core_dout_tvalid), .core_dout_tready(core_dout_tready),
        .m0_tdata(m0_tdata), .m0_tvalid(m0_tvalid), .m0_tready(m0_tready),
        .m1_tdata(m1_tdata), .m1_tvalid(m1_tvalid), .m1_tready(m1_tready),
        .err_timeout(err_timeout)
    );

    assign core_dout        = core_q;
    assign core_dout_tvalid = core_pend && (core_lat != 0) && (core_cnt >= core_lat);

    always @(posedge clk) begin
        if (core_din_tvalid && core_din_tready) begin
            core_pend <= 1'b1;
            core_q    <= core_din << 1;
            core_cnt  <= 1;
        end else if (core_pend) begin
            if (core_dout_tvalid && core_dout_tready) core_pend <= 1'b0;
            else                                      core_cnt  <= core_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int g, n0, n1, d0, d1;
        logic gch;
        logic gnt;

        rst_dut();
        @(negedge clk);
        chk("rst_s0_tready", 32'(s0_tready), 32'd0);
        chk("rst_m0_tvalid", 32'(m0_tvalid), 32'd0);
        chk("rst_m1_tvalid", 32'(m1_tvalid), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_core_din_tvalid", 32'(core_din_tvalid), 32'd0);
        chk("rst_core_dout_tready", 32'(core_dout_tready), 32'd1);
        chk("rst_m0_tdata", m0_tdata, 32'd0);

        // Single sample through the 1-cycle core
        cyc();
        s0_tvalid = 1'b1; s0_tdata = 32'h0000_0100;
        @(negedge clk);
        chk("single_s0_tready", 32'(s0_tready), 32'd1);
        chk("single_s1_tready", 32'(s1_tready), 32'd0);
        cyc();
        s0_tvalid = 1'b0;
        @(negedge clk);
        chk("single_issue_valid", 32'(core_din_tvalid), 32'd1);
        chk("single_issue_data", core_din, 32'h0000_0100);
        chk("single_issue_dout_rdy", 32'(core_dout_tready), 32'd0);
        cyc();
        @(negedge clk);
        chk("single_wait_m0v", 32'(m0_tvalid), 32'd0);
        cyc();
        @(negedge clk);
        chk("single_m0_tvalid", 32'(m0_tvalid), 32'd1);
        chk("single_m0_tdata", m0_tdata, 32'h0000_0200);
        chk("single_m1_tvalid", 32'(m1_tvalid), 32'd0);
        cyc();
        @(negedge clk);
        chk("single_m0_drop", 32'(m0_tvalid), 32'd0);
        chk("single_m0_hold", m0_tdata, 32'h0000_0200);

        // Continuous tie: grants alternate starting with channel 0
        rst_dut();
        g = 0; n0 = 0; n1 = 0; d0 = 0; d1 = 0;
        for (int c = 0; c < 40; c++) begin
            s0_tvalid = (g < 8);
            s1_tvalid = (g < 8);
            s0_tdata  = 32'h1000 + 32'(n0);
            s1_tdata  = 32'h2000 + 32'(n1);
            @(negedge clk);
            gnt = s0_tready || s1_tready;
            gch = s1_tready;
            if (gnt) begin
                chk("tie_grant_ch", 32'(gch), 32'(g % 2));
                chk("tie_excl", 32'(s0_tready && s1_tready), 32'd0);
            end
            if (m0_tvalid) begin
                chk("tie_m0_data", m0_tdata, (32'h1000 + 32'(d0)) << 1);
                d0++;
            end
            if (m1_tvalid) begin
                chk("tie_m1_data", m1_tdata, (32'h2000 + 32'(d1)) << 1);
                d1++;
            end
            cyc();
            if (gnt) begin
                g++;
                if (gch) n1++; else n0++;
            end
        end
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        chk("tie_grants", 32'(g), 32'd8);
        chk("tie_d0", 32'(d0), 32'd4);
        chk("tie_d1", 32'(d1), 32'd4);

        // Timeout: core silent, WAIT_TIMEOUT=4
        core_lat = 0;
        s0_tvalid = 1'b1; s0_tdata = 32'h0000_0055;
        @(negedge clk);
        chk("to_s0_tready", 32'(s0_tready), 32'd1);
        cyc();
        s0_tvalid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("to_last_wait_m0v", 32'(m0_tvalid), 32'd0);
        chk("to_last_wait_err", 32'(err_timeout), 32'd0);
        cyc();
        @(negedge clk);
        chk("to_m0_tvalid", 32'(m0_tvalid), 32'd1);
        chk("to_m0_tdata", m0_tdata, 32'd0);
        chk("to_err_set", 32'(err_timeout), 32'd1);
        cyc();
        @(negedge clk);
        chk("to_err_sticky", 32'(err_timeout), 32'd1);
        core_lat = 1;
        cyc();

        // Backpressure on m1 for 10 cycles while s0 waits
        m1_tready = 1'b0;
        s1_tvalid = 1'b1; s1_tdata = 32'h0000_0300;
        @(negedge clk);
        chk("bp_s1_tready", 32'(s1_tready), 32'd1);
        cyc();
        s1_tvalid = 1'b0;
        s0_tvalid = 1'b1; s0_tdata = 32'h0000_0077;
        repeat (2) begin
            @(negedge clk);
            chk("bp_busy_s0_tready", 32'(s0_tready), 32'd0);
            cyc();
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_m1_tvalid", 32'(m1_tvalid), 32'd1);
            chk("bp_m1_tdata", m1_tdata, 32'h0000_0600);
            chk("bp_s0_tready", 32'(s0_tready), 32'd0);
            cyc();
        end
        m1_tready = 1'b1;
        @(negedge clk);
        chk("bp_release_m1v", 32'(m1_tvalid), 32'd1);
        chk("bp_release_s0r", 32'(s0_tready), 32'd0);
        cyc();
        @(negedge clk);
        chk("bp_next_s0_tready", 32'(s0_tready), 32'd1);
        chk("bp_next_m1_tvalid", 32'(m1_tvalid), 32'd0);
        chk("bp_m1_hold", m1_tdata, 32'h0000_0600);
        cyc();
        s0_tvalid = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("bp_s0_result", m0_tdata, 32'h0000_00EE);
        chk("bp_s0_m0_tvalid", 32'(m0_tvalid), 32'd1);
        chk("bp_err_still", 32'(err_timeout), 32'd1);
        cyc();

        // Reset while waiting on a slow core; its late reply must be flushed
        core_lat = 3;
        s0_tvalid = 1'b1; s0_tdata = 32'h0000_0040;
        @(negedge clk);
        chk("rw_s0_tready", 32'(s0_tready), 32'd1);
        cyc();
        s0_tvalid = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("rw_in_wait", 32'(core_dout_tready), 32'd1);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rw_m0_tvalid", 32'(m0_tvalid), 32'd0);
        chk("rw_m1_tvalid", 32'(m1_tvalid), 32'd0);
        chk("rw_core_din_tvalid", 32'(core_din_tvalid), 32'd0);
        chk("rw_err_cleared", 32'(err_timeout), 32'd0);
        chk("rw_m0_zeroed", m0_tdata, 32'd0);
        cyc();
        @(negedge clk);
        chk("rw_flush_valid", 32'(core_dout_tvalid), 32'd1);
        chk("rw_flush_ready", 32'(core_dout_tready), 32'd1);
        chk("rw_flush_m0v", 32'(m0_tvalid), 32'd0);
        cyc();
        @(negedge clk);
        chk("rw_flushed", 32'(core_dout_tvalid), 32'd0);
        core_lat = 1;
        cyc();
        s1_tvalid = 1'b1; s1_tdata = 32'h0000_0123;
        @(negedge clk);
        chk("rw_new_s1_tready", 32'(s1_tready), 32'd1);
        cyc();
        s1_tvalid = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("rw_new_m1_tvalid", 32'(m1_tvalid), 32'd1);
        chk("rw_new_m1_tdata", m1_tdata, 32'h0000_0246);
        chk("rw_new_m0_tvalid", 32'(m0_tvalid), 32'd0);
        cyc();

`ifdef DISTORTION_SCHED_BYPASS_EN
        rst_dut();
        bypass = 2'b10;
        s1_tvalid = 1'b1; s1_tdata = 32'h7FFF_FFFF;
        @(negedge clk);
        chk("byp_s1_tready", 32'(s1_tready), 32'd1);
        chk("byp_core_idle0", 32'(core_din_tvalid), 32'd0);
        cyc();
        s1_tvalid = 1'b0;
        @(negedge clk);
        chk("byp_m1_tvalid", 32'(m1_tvalid), 32'd1);
        chk("byp_m1_tdata", m1_tdata, 32'h7FFF_FFFF);
        chk("byp_core_idle1", 32'(core_din_tvalid), 32'd0);
        cyc();
        @(negedge clk);
        chk("byp_core_idle2", 32'(core_din_tvalid), 32'd0);
        bypass = 2'b00;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
